axi_err_slave: RTL and testbench

- Terminating AXI4 slave that answers every transaction with DECERR.
- Attached to the spare slave port of axi_demux_raw / axi_crossbar, with BASE/MASK set to cover all unmapped address space. Unmapped accesses then complete cleanly instead of hanging the master.
- Accepts full bursts, drains write data and returns protocol-correct B and R responses with the original IDs.
- Multiple writes may be outstanding; reads are served one burst at a time.

---
 rtl/axi_err_slave_if.sv | 92 +++++++++
 rtl/axi_err_slave.sv | 204 ++++++++++++++++++++
 tb/tb_axi_err_slave.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_err_slave_if.sv
// AXI4 channel bundle used by axi_err_slave; clk/rstn travel with the bundle
// but the error slave runs from its own clk/rst ports.
interface axi_channel #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
) (
  input logic clk,
  input logic rstn
);
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;

  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;

  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport slave (
    input  clk, rstn,
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

  modport master (
    input  clk, rstn,
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );
endinterface

// File: rtl/axi_err_slave.sv
// Terminating AXI4 slave: every burst is accepted and answered with DECERR.
// Define AXI_ERR_SLAVE_LOG_EN to add the err_addr/err_cnt logging ports.
module axi_err_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int B_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_channel.slave             master
`ifdef AXI_ERR_SLAVE_LOG_EN
  ,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [15:0]           err_cnt
`endif
);
  localparam int PTR_W = $clog2(B_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] B_FULL = CNT_W'(B_DEPTH);
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic { W_IDLE, W_DRAIN } w_state_e;
  typedef enum logic { R_IDLE, R_SEND  } r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                aw_ready_q, aw_ready_d;
  logic                w_ready_q, w_ready_d;
  logic [ID_WIDTH-1:0] aw_id_q, aw_id_d;

  logic [ID_WIDTH-1:0] b_mem_q [B_DEPTH];
  logic [ID_WIDTH-1:0] b_mem_d [B_DEPTH];
  logic [PTR_W-1:0]    b_wr_ptr_q, b_wr_ptr_d;
  logic [PTR_W-1:0]    b_rd_ptr_q, b_rd_ptr_d;
  logic [CNT_W-1:0]    b_cnt_q, b_cnt_d;

  logic                ar_ready_q, ar_ready_d;
  logic [ID_WIDTH-1:0] r_id_q, r_id_d;
  logic [7:0]          r_len_q, r_len_d;
  logic [7:0]          beat_q, beat_d;

  logic aw_hs, w_last_hs, b_valid, b_push, b_pop;
  logic ar_hs, r_valid, r_last, r_hs;

  assign aw_hs     = master.aw_valid & aw_ready_q;
  assign w_last_hs = master.w_valid & w_ready_q & master.w_last;
  assign b_valid   = (b_cnt_q != '0);
  assign b_push    = w_last_hs;
  assign b_pop     = b_valid & master.b_ready;

  assign ar_hs   = master.ar_valid & ar_ready_q;
  assign r_valid = (r_state_q == R_SEND);
  assign r_last  = r_valid & (beat_q == r_len_q);
  assign r_hs    = r_valid & master.r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      aw_id_q    <= '0;
      b_mem_q    <= '{default: '0};
      b_wr_ptr_q <= '0;
      b_rd_ptr_q <= '0;
      b_cnt_q    <= '0;
      ar_ready_q <= 1'b0;
      r_id_q     <= '0;
      r_len_q    <= '0;
      beat_q     <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      aw_id_q    <= aw_id_d;
      b_mem_q    <= b_mem_d;
      b_wr_ptr_q <= b_wr_ptr_d;
      b_rd_ptr_q <= b_rd_ptr_d;
      b_cnt_q    <= b_cnt_d;
      ar_ready_q <= ar_ready_d;
      r_id_q     <= r_id_d;
      r_len_q    <= r_len_d;
      beat_q     <= beat_d;
    end
  end

  always_comb begin
    b_mem_d    = b_mem_q;
    b_wr_ptr_d = b_wr_ptr_q;
    b_rd_ptr_d = b_rd_ptr_q;
    b_cnt_d    = b_cnt_q;
    if (b_push) begin
      b_mem_d[b_wr_ptr_q] = aw_id_q;
      b_wr_ptr_d          = b_wr_ptr_q + PTR_W'(1);
    end
    if (b_pop) begin
      b_rd_ptr_d = b_rd_ptr_q + PTR_W'(1);
    end
    case ({b_push, b_pop})
      2'b10:   b_cnt_d = b_cnt_q + CNT_W'(1);
      2'b01:   b_cnt_d = b_cnt_q - CNT_W'(1);
      default: b_cnt_d = b_cnt_q;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs)     w_state_d = W_DRAIN;
      W_DRAIN: if (w_last_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // AW is only offered when the final B push of that burst is sure to fit.
  always_comb begin
    aw_id_d    = aw_hs ? master.aw_id : aw_id_q;
    aw_ready_d = (w_state_d == W_IDLE) && (b_cnt_d < B_FULL);
    w_ready_d  = (w_state_d == W_DRAIN);
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs)           r_state_d = R_SEND;
      R_SEND:  if (r_hs && r_last)  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    ar_ready_d = (r_state_d == R_IDLE);
    r_id_d     = ar_hs ? master.ar_id  : r_id_q;
    r_len_d    = ar_hs ? master.ar_len : r_len_q;
    beat_d     = beat_q;
    if (ar_hs) begin
      beat_d = '0;
    end else if (r_hs) begin
      beat_d = beat_q + 8'd1;
    end
  end

  assign master.aw_ready = aw_ready_q;
  assign master.w_ready  = w_ready_q;
  assign master.b_valid  = b_valid;
  assign master.b_id     = b_mem_q[b_rd_ptr_q];
  assign master.b_resp   = b_valid ? DECERR : 2'b00;
  assign master.b_user   = '0;
  assign master.ar_ready = ar_ready_q;
  assign master.r_valid  = r_valid;
  assign master.r_id     = r_id_q;
  assign master.r_data   = '0;
  assign master.r_resp   = r_valid ? DECERR : 2'b00;
  assign master.r_last   = r_last;
  assign master.r_user   = '0;

`ifdef AXI_ERR_SLAVE_LOG_EN
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic [16:0]           err_sum;

  // AR takes priority for the logged address when both handshake together.
  always_comb begin
    err_addr_d = err_addr_q;
    if (ar_hs) begin
      err_addr_d = master.ar_addr;
    end else if (aw_hs) begin
      err_addr_d = master.aw_addr;
    end
    err_sum   = {1'b0, err_cnt_q} + {16'd0, aw_hs} + {16'd0, ar_hs};
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_addr = err_addr_q;
  assign err_cnt  = err_cnt_q;
`endif

  logic unused_fields;
  assign unused_fields = ^{master.clk, master.rstn,
                           master.aw_len, master.aw_size, master.aw_burst,
                           master.aw_lock, master.aw_cache, master.aw_prot,
                           master.aw_qos, master.aw_region, master.aw_user,
                           master.w_data, master.w_strb, master.w_user,
                           master.ar_size, master.ar_burst, master.ar_lock,
                           master.ar_cache, master.ar_prot, master.ar_qos,
                           master.ar_region, master.ar_user
`ifndef AXI_ERR_SLAVE_LOG_EN
                           , master.aw_addr, master.ar_addr
`endif
                          };
endmodule

// File: tb/tb_axi_err_slave.sv
// Self-checking bench for axi_err_slave: directed scenarios then random traffic,
// every cycle compared against a queue-based transaction model.
module tb_axi_err_slave;
  localparam int ID_W    = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int B_DEPTH = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  axi_channel #(.ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W)) bus (
    .clk (clk),
    .rstn(!rst)
  );

`ifdef AXI_ERR_SLAVE_LOG_EN
  logic [ADDR_W-1:0] err_addr;
  logic [15:0]       err_cnt;
`endif

  axi_err_slave #(
    .ID_WIDTH  (ID_W),
    .ADDR_WIDTH(ADDR_W),
    .DATA_WIDTH(DATA_W),
    .B_DEPTH   (B_DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .master  (bus)
`ifdef AXI_ERR_SLAVE_LOG_EN
    ,
    .err_addr(err_addr),
    .err_cnt (err_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transaction-level model: pending B ids in issue order, pending R beats.
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            last;
  } rbeat_t;

  logic [ID_W-1:0] bq[$];
  rbeat_t          rq[$];
  logic            w_busy;
  logic [ID_W-1:0] w_id;
  logic            rst_seen;
  logic            aw_acc, w_acc, ar_acc, r_acc, b_acc;
  int              obs_r, obs_b;
`ifdef AXI_ERR_SLAVE_LOG_EN
  logic [ADDR_W-1:0] m_addr;
  int unsigned       m_cnt;
`endif

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic noteTimeout(input string tag);
    checks++;
    errors++;
    $error("[TB] FAIL %s observed=no_handshake expected=handshake", tag);
  endtask

  // Check current outputs against the model, then advance one clock.
  task automatic applyStimulus();
    logic e_awr, e_wr, e_bv, e_arr, e_rv, e_rl;
    e_awr = !rst_seen && !w_busy && (bq.size() < B_DEPTH);
    e_wr  = w_busy;
    e_bv  = (bq.size() != 0);
    e_arr = !rst_seen && (rq.size() == 0);
    e_rv  = (rq.size() != 0);
    e_rl  = 1'b0;
    if (e_rv) e_rl = rq[0].last;

    checkOutput("aw_ready", bus.aw_ready, e_awr);
    checkOutput("w_ready",  bus.w_ready,  e_wr);
    checkOutput("b_valid",  bus.b_valid,  e_bv);
    checkOutput("b_resp",   bus.b_resp,   e_bv ? 2'b11 : 2'b00);
    if (e_bv) checkOutput("b_id", bus.b_id, bq[0]);
    checkOutput("ar_ready", bus.ar_ready, e_arr);
    checkOutput("r_valid",  bus.r_valid,  e_rv);
    checkOutput("r_last",   bus.r_last,   e_rl);
    checkOutput("r_resp",   bus.r_resp,   e_rv ? 2'b11 : 2'b00);
    checkOutput("r_data",   bus.r_data,   64'd0);
    if (e_rv) checkOutput("r_id", bus.r_id, rq[0].id);
    if (rst_seen) begin
      checkOutput("rst_b_id", bus.b_id, 0);
      checkOutput("rst_r_id", bus.r_id, 0);
    end
`ifdef AXI_ERR_SLAVE_LOG_EN
    checkOutput("err_addr", err_addr, m_addr);
    checkOutput("err_cnt",  err_cnt,  m_cnt);
`endif

    if (!rst) begin
      if (bus.r_valid && bus.r_ready) obs_r++;
      if (bus.b_valid && bus.b_ready) obs_b++;
    end

    if (rst) begin
      bq.delete();
      rq.delete();
      w_busy   = 1'b0;
      rst_seen = 1'b1;
      aw_acc = 1'b0; w_acc = 1'b0; ar_acc = 1'b0; r_acc = 1'b0; b_acc = 1'b0;
`ifdef AXI_ERR_SLAVE_LOG_EN
      m_addr = '0;
      m_cnt  = 0;
`endif
    end else begin
      aw_acc = bus.aw_valid && e_awr;
      w_acc  = bus.w_valid && e_wr;
      b_acc  = e_bv && bus.b_ready;
      ar_acc = bus.ar_valid && e_arr;
      r_acc  = e_rv && bus.r_ready;
      if (b_acc) void'(bq.pop_front());
      if (w_acc && bus.w_last) begin
        bq.push_back(w_id);
        w_busy = 1'b0;
      end
      if (aw_acc) begin
        w_busy = 1'b1;
        w_id   = bus.aw_id;
      end
      if (r_acc) void'(rq.pop_front());
      if (ar_acc) begin
        for (int i = 0; i <= int'(bus.ar_len); i++) begin
          rq.push_back('{id: bus.ar_id, last: (i == int'(bus.ar_len))});
        end
      end
`ifdef AXI_ERR_SLAVE_LOG_EN
      if (ar_acc) m_addr = bus.ar_addr;
      else if (aw_acc) m_addr = bus.aw_addr;
      m_cnt = m_cnt + 32'(aw_acc) + 32'(ar_acc);
      if (m_cnt > 32'hFFFF) m_cnt = 32'hFFFF;
`endif
      rst_seen = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic sendAw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr);
    bus.aw_valid = 1'b1;
    bus.aw_id    = id;
    bus.aw_addr  = addr;
    bus.aw_len   = 8'($urandom);
    for (int i = 0; i < 30; i++) begin
      applyStimulus();
      if (aw_acc) break;
    end
    bus.aw_valid = 1'b0;
    if (!aw_acc) noteTimeout("aw_timeout");
  endtask

  task automatic sendW(input int beats);
    for (int b = 0; b < beats; b++) begin
      bus.w_valid = 1'b1;
      bus.w_last  = (b == beats - 1);
      bus.w_data  = {$urandom, $urandom};
      bus.w_strb  = 8'($urandom);
      for (int i = 0; i < 30; i++) begin
        applyStimulus();
        if (w_acc) break;
      end
      if (!w_acc) noteTimeout("w_timeout");
    end
    bus.w_valid = 1'b0;
    bus.w_last  = 1'b0;
  endtask

  task automatic sendAr(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input logic [7:0] len);
    bus.ar_valid = 1'b1;
    bus.ar_id    = id;
    bus.ar_addr  = addr;
    bus.ar_len   = len;
    for (int i = 0; i < 30; i++) begin
      applyStimulus();
      if (ar_acc) break;
    end
    bus.ar_valid = 1'b0;
    if (!ar_acc) noteTimeout("ar_timeout");
  endtask

  // mode 0: r_ready held high, mode 1: r_ready toggles every cycle.
  task automatic drainR(input int mode);
    for (int i = 0; i < 600 && rq.size() != 0; i++) begin
      bus.r_ready = (mode == 0) ? 1'b1 : ~bus.r_ready;
      applyStimulus();
    end
    bus.r_ready = 1'b0;
    if (rq.size() != 0) noteTimeout("r_drain_timeout");
  endtask

  task automatic drainB();
    bus.b_ready = 1'b1;
    for (int i = 0; i < 40 && bq.size() != 0; i++) applyStimulus();
    bus.b_ready = 1'b0;
    if (bq.size() != 0) noteTimeout("b_drain_timeout");
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.aw_valid = 0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0;
    bus.aw_size = 3'd3; bus.aw_burst = 2'b01; bus.aw_lock = 0; bus.aw_cache = '0;
    bus.aw_prot = '0; bus.aw_qos = '0; bus.aw_region = '0; bus.aw_user = '0;
    bus.w_valid = 0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 0; bus.w_user = '0;
    bus.b_ready = 0;
    bus.ar_valid = 0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0;
    bus.ar_size = 3'd3; bus.ar_burst = 2'b01; bus.ar_lock = 0; bus.ar_cache = '0;
    bus.ar_prot = '0; bus.ar_qos = '0; bus.ar_region = '0; bus.ar_user = '0;
    bus.r_ready = 0;
    w_busy = 0; w_id = '0; rst_seen = 1'b1;
    aw_acc = 0; w_acc = 0; ar_acc = 0; r_acc = 0; b_acc = 0;
    obs_r = 0; obs_b = 0;
`ifdef AXI_ERR_SLAVE_LOG_EN
    m_addr = '0; m_cnt = 0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] single write, W offered before AW");
    bus.w_valid = 1'b1;
    bus.w_last  = 1'b1;
    applyStimulus();
    applyStimulus();
    bus.w_valid = 1'b0;
    sendAw(4'd3, 32'h0000_0100);
    sendW(1);
    obs_b = 0;
    drainB();
    repeat (2) applyStimulus();
    checkOutput("single_b_count", obs_b, 1);

    $display("[TB] multi-beat write follows w_last only");
    sendAw(4'd7, 32'h0000_0200);
    sendW(3);
    drainB();

    $display("[TB] read burst len=3");
    obs_r = 0;
    sendAr(4'd5, 32'h0000_0300, 8'd3);
    drainR(0);
    applyStimulus();
    checkOutput("burst_beats", obs_r, 4);

    $display("[TB] B backpressure with full FIFO");
    obs_b = 0;
    bus.b_ready = 1'b0;
    for (int i = 0; i < B_DEPTH; i++) begin
      sendAw(ID_W'(8 + i), 32'h0000_1000 + 32'(i));
      sendW(1);
    end
    bus.aw_valid = 1'b1;
    bus.aw_id    = 4'd12;
    repeat (3) applyStimulus();
    checkOutput("bp_blocked_aw", aw_acc, 0);
    bus.b_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      if (aw_acc) break;
    end
    bus.aw_valid = 1'b0;
    if (!aw_acc) noteTimeout("bp_aw_timeout");
    sendW(1);
    drainB();
    checkOutput("bp_b_count", obs_b, 5);

    $display("[TB] R stall with toggling r_ready");
    obs_r = 0;
    sendAr(4'd6, 32'h0000_0400, 8'd1);
    drainR(1);
    applyStimulus();
    checkOutput("stall_beats", obs_r, 2);

    $display("[TB] simultaneous AW and AR");
    bus.aw_valid = 1'b1; bus.aw_id = 4'd2; bus.aw_addr = 32'h0000_0500;
    bus.ar_valid = 1'b1; bus.ar_id = 4'd4; bus.ar_addr = 32'h0000_0600; bus.ar_len = 8'd0;
    applyStimulus();
    checkOutput("both_accepted", {aw_acc, ar_acc}, 2'b11);
    bus.aw_valid = 1'b0;
    bus.ar_valid = 1'b0;
    sendW(1);
    drainR(0);
    drainB();

    $display("[TB] 256-beat read");
    obs_r = 0;
    sendAr(4'd15, 32'h0000_0700, 8'd255);
    drainR(0);
    checkOutput("long_beats", obs_r, 256);

    $display("[TB] reset during read beat 2");
    obs_r = 0;
    sendAr(4'd9, 32'h0000_0800, 8'd3);
    bus.r_ready = 1'b1;
    applyStimulus();
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    repeat (4) applyStimulus();
    bus.r_ready = 1'b0;
    checkOutput("rst_beats", obs_r, 2);

`ifdef AXI_ERR_SLAVE_LOG_EN
    $display("[TB] address/count logging");
    resetDut();
    sendAw(4'd1, 32'h0000_1000);
    sendW(1);
    sendAr(4'd2, 32'h0000_2000, 8'd0);
    drainR(0);
    drainB();
    checkOutput("log_addr", err_addr, 32'h0000_2000);
    checkOutput("log_cnt",  err_cnt,  16'd2);
`endif

    $display("[TB] random traffic");
    resetDut();
    for (int cyc = 0; cyc < 2500; cyc++) begin
      if (!bus.aw_valid) begin
        bus.aw_valid = ($urandom_range(0, 3) == 0);
        bus.aw_id    = ID_W'($urandom);
        bus.aw_addr  = $urandom;
        bus.aw_len   = 8'($urandom);
      end
      if (!bus.w_valid) begin
        bus.w_valid = ($urandom_range(0, 1) == 0);
        bus.w_last  = ($urandom_range(0, 2) == 0);
        bus.w_data  = {$urandom, $urandom};
        bus.w_strb  = 8'($urandom);
      end
      if (!bus.ar_valid) begin
        bus.ar_valid = ($urandom_range(0, 5) == 0);
        bus.ar_id    = ID_W'($urandom);
        bus.ar_addr  = $urandom;
        bus.ar_len   = ($urandom_range(0, 31) == 0) ? 8'd255 : 8'($urandom_range(0, 7));
      end
      bus.b_ready = ($urandom_range(0, 2) != 0);
      bus.r_ready = ($urandom_range(0, 3) != 0);
      rst         = ($urandom_range(0, 299) == 0);
      applyStimulus();
      if (aw_acc) bus.aw_valid = 1'b0;
      if (w_acc)  bus.w_valid  = 1'b0;
      if (ar_acc) bus.ar_valid = 1'b0;
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
